// File: rtl/ifetch_unit.sv
// Non-pipelined instruction fetch/sequencing unit: fetches one word, waits for the
// registered decoder, waits for the datapath, then selects the next PC.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEC_LAT  = 1
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [5:0]  funct,
    output logic        instr_valid,
    input  logic        Jump,
    input  logic        Branch,
    input  logic        JumpSel,
    input  logic        br_taken,
    input  logic [31:0] jr_target,
    input  logic        exec_done,
    input  logic        halt,
    output logic [31:0] pc,
    output logic [31:0] link_addr,
    output logic        halted,
    output logic [31:0] retired
);

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_DECODE = 2'd1,
        S_EXEC   = 2'd2,
        S_HALT   = 2'd3
    } state_t;

    localparam logic [3:0] DEC_LAST = 4'(DEC_LAT - 1);

    state_t      state;
    state_t      state_next;
    logic [3:0]  cnt;
    logic        accept;
    logic        retire;
    logic [31:0] pc_plus4;
    logic [31:0] pc_next;

    function automatic logic [31:0] next_pc_f(
        input logic [31:0] cur_p4,
        input logic [25:0] idx,
        input logic [29:0] jr_word,
        input logic        jump,
        input logic        branch,
        input logic        jsel,
        input logic        taken
    );
        logic signed [31:0] br_off;
        br_off = {{14{idx[15]}}, idx[15:0], 2'b00};
        // Jump outranks Branch when the decoder raises both.
        if (jump && jsel) begin
            next_pc_f = {jr_word, 2'b00};
        end else if (jump) begin
            next_pc_f = {cur_p4[31:28], idx, 2'b00};
        end else if (branch && taken) begin
            next_pc_f = cur_p4 + br_off;
        end else begin
            next_pc_f = cur_p4;
        end
    endfunction

    assign pc_plus4  = pc + 32'd4;
    assign link_addr = pc_plus4;
    assign imem_addr = pc;
    assign opcode    = instr[31:26];
    assign funct     = instr[5:0];
    assign halted    = (state == S_HALT);

    // The request register is low right after reset, so a stale ack is never accepted.
    assign accept = (state == S_FETCH) && imem_req && imem_ack;
    assign retire = (state == S_EXEC) && exec_done && !halt;
    assign pc_next = next_pc_f(pc_plus4, instr[25:0], jr_target[31:2],
                               Jump, Branch, JumpSel, br_taken);

    always_comb begin
        state_next = state;
        case (state)
            S_FETCH: begin
                if (accept) begin
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                if (halt) begin
                    state_next = S_HALT;
                end else if (cnt == DEC_LAST) begin
                    state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                if (halt) begin
                    state_next = S_HALT;
                end else if (exec_done) begin
                    state_next = S_FETCH;
                end
            end
            default: state_next = S_HALT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_FETCH;
            pc          <= RESET_PC;
            instr       <= 32'd0;
            instr_valid <= 1'b0;
            imem_req    <= 1'b0;
            retired     <= 32'd0;
            cnt         <= 4'd0;
        end else begin
            state       <= state_next;
            imem_req    <= (state_next == S_FETCH);
            instr_valid <= accept;
            if (accept) begin
                instr <= imem_rdata;
                cnt   <= 4'd0;
            end else if (state == S_DECODE) begin
                cnt <= cnt + 4'd1;
            end
            if (retire) begin
                pc      <= pc_next;
                retired <= retired + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: directed vector table, reset/halt corner sequences and a
// randomized instruction stream checked against a next-PC reference model.
module tb_ifetch_unit;

    localparam int          DEC_LAT  = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        instr_valid;
    logic        Jump;
    logic        Branch;
    logic        JumpSel;
    logic        br_taken;
    logic [31:0] jr_target;
    logic        exec_done;
    logic        halt;
    logic [31:0] pc;
    logic [31:0] link_addr;
    logic        halted;
    logic [31:0] retired;

    ifetch_unit #(.RESET_PC(RESET_PC), .DEC_LAT(DEC_LAT)) dut (
        .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr), .opcode(opcode),
        .funct(funct), .instr_valid(instr_valid), .Jump(Jump), .Branch(Branch),
        .JumpSel(JumpSel), .br_taken(br_taken), .jr_target(jr_target),
        .exec_done(exec_done), .halt(halt), .pc(pc), .link_addr(link_addr),
        .halted(halted), .retired(retired)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    logic [31:0] m_pc;
    logic [31:0] m_ret;

    typedef struct {
        logic [31:0] word;
        logic        j;
        logic        b;
        logic        js;
        logic        bt;
        logic [31:0] jrt;
        logic [31:0] exp_pc;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Next PC from the architectural rules, using plain arithmetic.
    function automatic logic [31:0] ref_next(input logic [31:0] cur, input logic [31:0] word,
                                             input logic j, input logic b, input logic js,
                                             input logic bt, input logic [31:0] jrt);
        logic [31:0]        p4;
        logic signed [15:0] imm;
        int                 off;
        p4  = cur + 32'd4;
        imm = word[15:0];
        off = int'(imm) * 4;
        if (j && js) return jrt - (jrt % 32'd4);
        if (j)       return (p4 / 32'h1000_0000) * 32'h1000_0000 + (word % 32'h0400_0000) * 32'd4;
        if (b && bt) return p4 + 32'(off);
        return p4;
    endfunction

    task automatic clear_inputs();
        imem_ack = 1'b0; imem_rdata = 32'd0; Jump = 1'b0; Branch = 1'b0; JumpSel = 1'b0;
        br_taken = 1'b0; jr_target = 32'd0; exec_done = 1'b0; halt = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chkb("rst_req", imem_req, 1'b0);
        chk("rst_pc", pc, RESET_PC);
        chk("rst_instr", instr, 32'd0);
        chkb("rst_valid", instr_valid, 1'b0);
        chkb("rst_halted", halted, 1'b0);
        chk("rst_retired", retired, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chkb("req_after_rst", imem_req, 1'b1);
        m_pc  = RESET_PC;
        m_ret = 32'd0;
    endtask

    // Ends at the falling edge inside the first DECODE cycle.
    task automatic fetch_phase(input logic [31:0] word, input int ack_dly, input bit noise);
        int n;
        n = 0;
        while (imem_req !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chkb("req_wait", imem_req, 1'b1);
        chk("imem_addr", imem_addr, m_pc);
        for (int i = 0; i < ack_dly; i++) begin
            halt = noise;
            @(negedge clk);
            chkb("req_hold", imem_req, 1'b1);
        end
        halt = 1'b0;
        imem_ack = 1'b1;
        imem_rdata = word;
        @(negedge clk);
        imem_ack = 1'b0;
        chkb("valid_pulse", instr_valid, 1'b1);
        chk("instr", instr, word);
        chk("opcode", {26'd0, opcode}, word >> 26);
        chk("funct", {26'd0, funct}, word % 32'd64);
        chkb("req_drop", imem_req, 1'b0);
    endtask

    task automatic decode_wait(input logic [31:0] word, input bit noise);
        for (int i = 0; i < DEC_LAT; i++) begin
            imem_ack = noise;
            imem_rdata = ~word;
            exec_done = noise;
            @(negedge clk);
            if (i == 0) chkb("valid_low", instr_valid, 1'b0);
        end
        imem_ack = 1'b0;
        exec_done = 1'b0;
        chk("instr_hold", instr, word);
    endtask

    task automatic do_instr(input logic [31:0] word, input logic j, input logic b,
                            input logic js, input logic bt, input logic [31:0] jrt,
                            input int ack_dly, input int exe_dly, input bit noise,
                            input logic [31:0] exp_pc);
        fetch_phase(word, ack_dly, noise);
        decode_wait(word, noise);
        chk("link_addr", link_addr, m_pc + 32'd4);
        for (int i = 0; i < exe_dly; i++) begin
            imem_ack = noise;
            @(negedge clk);
        end
        imem_ack = 1'b0;
        chk("pc_wait", pc, m_pc);
        Jump = j; Branch = b; JumpSel = js; br_taken = bt; jr_target = jrt;
        exec_done = 1'b1;
        @(negedge clk);
        clear_inputs();
        m_pc  = exp_pc;
        m_ret = m_ret + 32'd1;
        chk("pc_next", pc, m_pc);
        chk("retired", retired, m_ret);
        chkb("req_refetch", imem_req, 1'b1);
        chkb("not_halted", halted, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs[$];
        logic [31:0] w, jt, e;
        logic rj, rb, rjs, rbt;

        vecs.push_back('{32'h012A_4020, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0000_0004});
        vecs.push_back('{32'h03E0_0008, 1'b1, 1'b0, 1'b1, 1'b0, 32'h1000_0013, 32'h1000_0010});
        vecs.push_back('{32'h0800_0040, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         32'h1000_0100});
        vecs.push_back('{32'h03E0_0008, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0020, 32'h0000_0020});
        vecs.push_back('{32'h1420_FFFE, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0,         32'h0000_001C});
        vecs.push_back('{32'h03E0_0008, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0020, 32'h0000_0020});
        vecs.push_back('{32'h1420_FFFE, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         32'h0000_0024});
        vecs.push_back('{32'h03E0_0008, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0203, 32'h0000_0200});
        vecs.push_back('{32'h0800_0010, 1'b1, 1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF, 32'h0000_0040});
        vecs.push_back('{32'h1420_0004, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0,         32'h0000_0054});
        vecs.push_back('{32'h03E0_0008, 1'b1, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFC});
        vecs.push_back('{32'h012A_4020, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0000_0000});
        vecs.push_back('{32'h1420_FFFF, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0,         32'h0000_0000});
        vecs.push_back('{32'h012A_4020, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0000_0004});

        do_reset();

        foreach (vecs[i]) begin
            do_instr(vecs[i].word, vecs[i].j, vecs[i].b, vecs[i].js, vecs[i].bt, vecs[i].jrt,
                     (i == 0) ? 2 : i % 3, i % 2, (i % 2) == 1, vecs[i].exp_pc);
        end

        // Reset while a request is outstanding; the following ack must be dropped.
        @(negedge clk);
        chkb("t6_req_pre", imem_req, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        imem_ack = 1'b1;
        imem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        imem_ack = 1'b0;
        chk("t6_instr", instr, 32'd0);
        chkb("t6_valid", instr_valid, 1'b0);
        chk("t6_pc", pc, RESET_PC);
        chk("t6_retired", retired, 32'd0);
        chkb("t6_req", imem_req, 1'b1);
        @(negedge clk);
        chkb("t6_valid2", instr_valid, 1'b0);
        m_pc  = RESET_PC;
        m_ret = 32'd0;

        for (int n = 0; n < 40; n++) begin
            w   = $urandom;
            jt  = $urandom;
            rj  = 1'($urandom_range(0, 3) == 0);
            rb  = 1'($urandom_range(0, 1));
            rjs = 1'($urandom_range(0, 1));
            rbt = 1'($urandom_range(0, 1));
            e   = ref_next(m_pc, w, rj, rb, rjs, rbt, jt);
            do_instr(w, rj, rb, rjs, rbt, jt, $urandom_range(0, 3), $urandom_range(0, 3),
                     1'($urandom_range(0, 1)), e);
        end

        // halt and exec_done together: halt wins, nothing retires.
        fetch_phase(32'h03E0_0008, 1, 1'b0);
        decode_wait(32'h03E0_0008, 1'b0);
        Jump = 1'b1; JumpSel = 1'b1; jr_target = 32'h0000_1234;
        halt = 1'b1;
        exec_done = 1'b1;
        @(negedge clk);
        clear_inputs();
        chkb("t5_halted", halted, 1'b1);
        chk("t5_pc", pc, m_pc);
        chk("t5_retired", retired, m_ret);
        chkb("t5_req", imem_req, 1'b0);
        exec_done = 1'b1;
        imem_ack = 1'b1;
        repeat (3) @(negedge clk);
        clear_inputs();
        chkb("t5_absorb", halted, 1'b1);
        chk("t5_pc2", pc, m_pc);
        chk("t5_retired2", retired, m_ret);
        chkb("t5_req2", imem_req, 1'b0);

        do_reset();

        // halt sampled during DECODE.
        fetch_phase(32'h012A_4020, 0, 1'b0);
        halt = 1'b1;
        @(negedge clk);
        halt = 1'b0;
        chkb("dec_halt", halted, 1'b1);
        chkb("dec_halt_req", imem_req, 1'b0);
        chk("dec_halt_ret", retired, 32'd0);
        chk("dec_halt_pc", pc, RESET_PC);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
